// File: rtl/rvfi_pkg.sv
// Purpose: shared record type, constants and illegal-instruction canonicaliser for the RVFI retire path.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Contents: rvfi_rec_t (one retired instruction plus its load-pending flag),
//           RVFI_MODE_M, RVFI_ORDER_W, rvfi_canon_illegal().
package rvfi_pkg;

    // Record layout is fixed at these widths; the modules' XLEN/ILEN must match.
    localparam int         RVFI_XLEN    = 32;
    localparam int         RVFI_ILEN    = 32;
    localparam int         RVFI_ORDER_W = 64;
    localparam logic [1:0] RVFI_MODE_M  = 2'b11;

    typedef struct packed {
        logic [RVFI_ILEN-1:0]   insn;
        logic [RVFI_XLEN-1:0]   pc_rdata;
        logic [RVFI_XLEN-1:0]   pc_wdata;
        logic                   trap;
        logic                   intr;
        logic                   halt;
        logic [4:0]             rs1_addr;
        logic [4:0]             rs2_addr;
        logic [4:0]             rd_addr;
        logic [RVFI_XLEN-1:0]   rs1_rdata;
        logic [RVFI_XLEN-1:0]   rs2_rdata;
        logic [RVFI_XLEN-1:0]   rd_wdata;
        logic [RVFI_XLEN-1:0]   mem_addr;
        logic [RVFI_XLEN/8-1:0] mem_rmask;
        logic [RVFI_XLEN/8-1:0] mem_wmask;
        logic [RVFI_XLEN-1:0]   mem_rdata;
        logic [RVFI_XLEN-1:0]   mem_wdata;
        logic                   pending;    // load still waiting for its data response
    } rvfi_rec_t;

    // An illegal instruction retires as a trap with no architectural side effects;
    // pc_wdata is left as supplied (trap target chosen by the core).
    function automatic rvfi_rec_t rvfi_canon_illegal(input rvfi_rec_t rec);
        rvfi_rec_t r;
        r           = rec;
        r.trap      = 1'b1;
        r.rd_addr   = 5'd0;
        r.rd_wdata  = '0;
        r.mem_rmask = '0;
        r.mem_wmask = '0;
        r.mem_rdata = '0;
        return r;
    endfunction

endpackage

// File: rtl/rvfi_retire_gen_if.sv
// Purpose: retire-record channel from the core writeback stage to the RVFI generator.
// Latency: n/a (wires only).
// Backpressure: record transfers when ret_valid && ret_ready.
// Modports: master = core writeback (drives the record), slave = rvfi_retire_gen.
interface rvfi_retire_gen_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) ();
    logic              ret_valid;
    logic              ret_ready;
    logic [ILEN-1:0]   ret_insn;
    logic [XLEN-1:0]   ret_pc;
    logic [XLEN-1:0]   ret_next_pc;
    logic              ret_illegal;
    logic              ret_trap;
    logic              ret_intr;
    logic              ret_halt;
    logic [4:0]        ret_rs1_addr;
    logic [4:0]        ret_rs2_addr;
    logic [4:0]        ret_rd_addr;
    logic [XLEN-1:0]   ret_rs1_rdata;
    logic [XLEN-1:0]   ret_rs2_rdata;
    logic [XLEN-1:0]   ret_rd_wdata;
    logic [XLEN-1:0]   ret_mem_addr;
    logic [XLEN-1:0]   ret_mem_wdata;
    logic [XLEN/8-1:0] ret_mem_rmask;
    logic [XLEN/8-1:0] ret_mem_wmask;

    modport master (
        output ret_valid, ret_insn, ret_pc, ret_next_pc, ret_illegal, ret_trap, ret_intr,
               ret_halt, ret_rs1_addr, ret_rs2_addr, ret_rd_addr, ret_rs1_rdata,
               ret_rs2_rdata, ret_rd_wdata, ret_mem_addr, ret_mem_wdata, ret_mem_rmask,
               ret_mem_wmask,
        input  ret_ready
    );

    modport slave (
        input  ret_valid, ret_insn, ret_pc, ret_next_pc, ret_illegal, ret_trap, ret_intr,
               ret_halt, ret_rs1_addr, ret_rs2_addr, ret_rd_addr, ret_rs1_rdata,
               ret_rs2_rdata, ret_rd_wdata, ret_mem_addr, ret_mem_wdata, ret_mem_rmask,
               ret_mem_wmask,
        output ret_ready
    );
endinterface

// File: rtl/rvfi_retire_buf.sv
// Purpose: DEPTH-entry in-order circular store of retire records with in-place load completion.
// Latency: written entry visible at head the cycle after the write.
// Backpressure: full_o when DEPTH entries held; caller must not write while full.
// Ports: clock/reset (sync, active-low); wr_en_i/wr_rec_i write at tail; pop_i advances head;
//        ld_cpl_i + data complete the oldest pending load; head_rec_o/head_vld_o, full_o, ld_hit_o.
module rvfi_retire_buf
    import rvfi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 wr_en_i,
    input  rvfi_rec_t            wr_rec_i,
    input  logic                 pop_i,
    input  logic                 ld_cpl_i,
    input  logic [RVFI_XLEN-1:0] ld_mem_rdata_i,
    input  logic [RVFI_XLEN-1:0] ld_rd_wdata_i,
    output rvfi_rec_t            head_rec_o,
    output logic                 head_vld_o,
    output logic                 full_o,
    output logic                 ld_hit_o
);
    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   head_q, head_d, tail_q, tail_d, count;
    logic [AW-1:0] ld_ptr;
    rvfi_rec_t     mem_q [DEPTH];

    assign count      = tail_q - head_q;
    assign head_vld_o = (head_q != tail_q);
    assign full_o     = (head_q[AW] != tail_q[AW]) && (head_q[AW-1:0] == tail_q[AW-1:0]);
    assign head_rec_o = mem_q[head_q[AW-1:0]];

    // Pending-load pointer: oldest occupied entry still pending, searched from head.
    // Walking downward lets the oldest match win. Only registered state is looked at,
    // so a load written this cycle cannot take this cycle's response.
    always_comb begin
        ld_hit_o = 1'b0;
        ld_ptr   = head_q[AW-1:0];
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (((AW+1)'(i) < count) && mem_q[head_q[AW-1:0] + AW'(i)].pending) begin
                ld_hit_o = 1'b1;
                ld_ptr   = head_q[AW-1:0] + AW'(i);
            end
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (wr_en_i) tail_d = tail_q + 1'b1;
        if (pop_i)   head_d = head_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Storage is not reset: occupancy is defined purely by the pointers.
    // Completion and tail write never alias: the pending entry is occupied, the tail is not.
    always_ff @(posedge clock) begin
        if (wr_en_i) mem_q[tail_q[AW-1:0]] <= wr_rec_i;
        if (ld_cpl_i && ld_hit_o) begin
            mem_q[ld_ptr].mem_rdata <= ld_mem_rdata_i;
            if (mem_q[ld_ptr].rd_addr != 5'd0) mem_q[ld_ptr].rd_wdata <= ld_rd_wdata_i;
            mem_q[ld_ptr].pending <= 1'b0;
        end
    end
endmodule

// File: rtl/rvfi_retire_gen.sv
// Purpose: single-channel RVFI producer; buffers in-order retirements, waits for load data, emits with order.
// Latency: non-load emits 1 cycle after acceptance into an empty buffer; load emits 1 cycle after its response.
// Backpressure: ret_ready = !full && !halted (low in reset); no bypass when the head emits in the same cycle.
// Ports: clock/reset (sync, active-low); ret = retire channel (slave); ld_resp_* load data for the
//        oldest pending load; rvfi_* registered RVFI outputs; ld_err sticky unmatched-response flag.
module rvfi_retire_gen
    import rvfi_pkg::*;
#(
    parameter int XLEN  = RVFI_XLEN,
    parameter int ILEN  = RVFI_ILEN,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    rvfi_retire_gen_if.slave        ret,
    input  logic                    ld_resp_valid,
    input  logic [XLEN-1:0]         ld_mem_rdata,
    input  logic [XLEN-1:0]         ld_rd_wdata,
    output logic                    rvfi_valid,
    output logic [RVFI_ORDER_W-1:0] rvfi_order,
    output logic [ILEN-1:0]         rvfi_insn,
    output logic                    rvfi_trap,
    output logic                    rvfi_halt,
    output logic                    rvfi_intr,
    output logic [1:0]              rvfi_mode,
    output logic [4:0]              rvfi_rs1_addr,
    output logic [4:0]              rvfi_rs2_addr,
    output logic [XLEN-1:0]         rvfi_rs1_rdata,
    output logic [XLEN-1:0]         rvfi_rs2_rdata,
    output logic [4:0]              rvfi_rd_addr,
    output logic [XLEN-1:0]         rvfi_rd_wdata,
    output logic [XLEN-1:0]         rvfi_pc_rdata,
    output logic [XLEN-1:0]         rvfi_pc_wdata,
    output logic [XLEN-1:0]         rvfi_mem_addr,
    output logic [XLEN/8-1:0]       rvfi_mem_rmask,
    output logic [XLEN/8-1:0]       rvfi_mem_wmask,
    output logic [XLEN-1:0]         rvfi_mem_rdata,
    output logic [XLEN-1:0]         rvfi_mem_wdata,
    output logic                    ld_err
);
    rvfi_rec_t               rec_in, head_rec;
    logic                    accept, pop, head_vld, buf_full, ld_hit;
    logic                    halted_q, halted_d, ld_err_d;
    logic [RVFI_ORDER_W-1:0] order_q, order_d;

    assign ret.ret_ready = reset && !buf_full && !halted_q;
    assign accept        = ret.ret_valid && ret.ret_ready;
    assign pop           = head_vld && !head_rec.pending;

    always_comb begin
        rec_in           = '0;
        rec_in.insn      = ret.ret_insn;
        rec_in.pc_rdata  = ret.ret_pc;
        rec_in.pc_wdata  = ret.ret_next_pc;
        rec_in.trap      = ret.ret_trap;
        rec_in.intr      = ret.ret_intr;
        rec_in.halt      = ret.ret_halt;
        rec_in.rs1_addr  = ret.ret_rs1_addr;
        rec_in.rs2_addr  = ret.ret_rs2_addr;
        rec_in.rd_addr   = ret.ret_rd_addr;
        rec_in.rs1_rdata = ret.ret_rs1_rdata;
        rec_in.rs2_rdata = ret.ret_rs2_rdata;
        // Load writeback value only exists once the response arrives.
        rec_in.rd_wdata  = (ret.ret_mem_rmask != '0) ? '0 : ret.ret_rd_wdata;
        rec_in.mem_addr  = ret.ret_mem_addr;
        rec_in.mem_rmask = ret.ret_mem_rmask;
        rec_in.mem_wmask = ret.ret_mem_wmask;
        rec_in.mem_wdata = ret.ret_mem_wdata;
        if (ret.ret_illegal) rec_in = rvfi_canon_illegal(rec_in);
        if (rec_in.rd_addr == 5'd0) rec_in.rd_wdata = '0;
        // Canonicalisation clears rmask, so an illegal "load" never waits for data.
        rec_in.pending   = (rec_in.mem_rmask != '0);
    end

    rvfi_retire_buf #(.DEPTH(DEPTH)) u_buf (
        .clock          (clock),
        .reset          (reset),
        .wr_en_i        (accept),
        .wr_rec_i       (rec_in),
        .pop_i          (pop),
        .ld_cpl_i       (ld_resp_valid),
        .ld_mem_rdata_i (ld_mem_rdata),
        .ld_rd_wdata_i  (ld_rd_wdata),
        .head_rec_o     (head_rec),
        .head_vld_o     (head_vld),
        .full_o         (buf_full),
        .ld_hit_o       (ld_hit)
    );

    assign halted_d = halted_q || (pop && head_rec.halt);
    assign order_d  = order_q + RVFI_ORDER_W'(pop);
    assign ld_err_d = ld_err || (ld_resp_valid && !ld_hit);

    always_ff @(posedge clock) begin
        if (!reset) begin
            halted_q <= 1'b0;
            order_q  <= '0;
            ld_err   <= 1'b0;
        end else begin
            halted_q <= halted_d;
            order_q  <= order_d;
            ld_err   <= ld_err_d;
        end
    end

    // Output register: payload only updates on an emit, so it holds between pulses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rvfi_valid     <= 1'b0;
            rvfi_order     <= '0;
            rvfi_insn      <= '0;
            rvfi_trap      <= 1'b0;
            rvfi_halt      <= 1'b0;
            rvfi_intr      <= 1'b0;
            rvfi_mode      <= 2'b00;
            rvfi_rs1_addr  <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rd_addr   <= '0;
            rvfi_rd_wdata  <= '0;
            rvfi_pc_rdata  <= '0;
            rvfi_pc_wdata  <= '0;
            rvfi_mem_addr  <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
        end else begin
            rvfi_valid <= pop;
            if (pop) begin
                rvfi_order     <= order_q;
                rvfi_insn      <= head_rec.insn;
                rvfi_trap      <= head_rec.trap;
                rvfi_halt      <= head_rec.halt;
                rvfi_intr      <= head_rec.intr;
                rvfi_mode      <= RVFI_MODE_M;
                rvfi_rs1_addr  <= head_rec.rs1_addr;
                rvfi_rs2_addr  <= head_rec.rs2_addr;
                rvfi_rs1_rdata <= head_rec.rs1_rdata;
                rvfi_rs2_rdata <= head_rec.rs2_rdata;
                rvfi_rd_addr   <= head_rec.rd_addr;
                rvfi_rd_wdata  <= head_rec.rd_wdata;
                rvfi_pc_rdata  <= head_rec.pc_rdata;
                rvfi_pc_wdata  <= head_rec.pc_wdata;
                rvfi_mem_addr  <= head_rec.mem_addr;
                rvfi_mem_rmask <= head_rec.mem_rmask;
                rvfi_mem_wmask <= head_rec.mem_wmask;
                rvfi_mem_rdata <= head_rec.mem_rdata;
                rvfi_mem_wdata <= head_rec.mem_wdata;
            end
        end
    end
endmodule

// File: tb/tb_rvfi_retire_gen.sv
module tb_rvfi_retire_gen;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rvfi_retire_gen_if #(.XLEN(32), .ILEN(32)) ret_if ();

    logic        ld_resp_valid = 1'b0;
    logic [31:0] ld_mem_rdata  = '0;
    logic [31:0] ld_rd_wdata   = '0;
    logic        rvfi_valid, rvfi_trap, rvfi_halt, rvfi_intr, ld_err;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

    rvfi_retire_gen #(.XLEN(32), .ILEN(32), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .ret(ret_if),
        .ld_resp_valid(ld_resp_valid), .ld_mem_rdata(ld_mem_rdata), .ld_rd_wdata(ld_rd_wdata),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .ld_err(ld_err)
    );

    typedef struct packed {
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap, halt, intr;
        logic [1:0]  mode;
        logic [4:0]  rs1_addr, rs2_addr, rd_addr;
        logic [31:0] rs1_rdata, rs2_rdata, rd_wdata, pc_rdata, pc_wdata, mem_addr;
        logic [3:0]  rmask, wmask;
        logic [31:0] mem_rdata, mem_wdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] exp_order = '0;
    int          checks    = 0;
    int          errors    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rvfi_valid pulse must match the oldest expected record.
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clock);
            if (rvfi_valid === 1'b1) begin
                a = '{order: rvfi_order, insn: rvfi_insn, trap: rvfi_trap, halt: rvfi_halt,
                      intr: rvfi_intr, mode: rvfi_mode, rs1_addr: rvfi_rs1_addr,
                      rs2_addr: rvfi_rs2_addr, rd_addr: rvfi_rd_addr, rs1_rdata: rvfi_rs1_rdata,
                      rs2_rdata: rvfi_rs2_rdata, rd_wdata: rvfi_rd_wdata, pc_rdata: rvfi_pc_rdata,
                      pc_wdata: rvfi_pc_wdata, mem_addr: rvfi_mem_addr, rmask: rvfi_mem_rmask,
                      wmask: rvfi_mem_wmask, mem_rdata: rvfi_mem_rdata, mem_wdata: rvfi_mem_wdata};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_emit: got order %0d pc %0h, expected no emission", rvfi_order, rvfi_pc_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL rvfi_record order %0d: got %h expected %h", e.order, a, e);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Offer one record; wait up to 'budget' cycles for acceptance. Expected record
    // is queued only if accepted. Non-load side fields derive from pc.
    task automatic offer(input logic [31:0] insn, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] rdw, input logic [3:0] rmask, input logic [3:0] wmask,
                         input logic illegal, input logic halt, input logic exp_trap,
                         input logic [4:0] exp_rd, input logic [31:0] exp_rdw,
                         input logic [3:0] exp_rmask, input logic [3:0] exp_wmask,
                         input logic [31:0] exp_mrdata, input int budget, output bit ok);
        exp_t e;
        ret_if.ret_valid     = 1'b1;
        ret_if.ret_insn      = insn;
        ret_if.ret_pc        = pc;
        ret_if.ret_next_pc   = pc + 32'd4;
        ret_if.ret_illegal   = illegal;
        ret_if.ret_trap      = 1'b0;
        ret_if.ret_intr      = 1'b0;
        ret_if.ret_halt      = halt;
        ret_if.ret_rs1_addr  = 5'd2;
        ret_if.ret_rs2_addr  = 5'd3;
        ret_if.ret_rd_addr   = rd;
        ret_if.ret_rs1_rdata = pc + 32'h11;
        ret_if.ret_rs2_rdata = pc + 32'h22;
        ret_if.ret_rd_wdata  = rdw;
        ret_if.ret_mem_addr  = pc + 32'h100;
        ret_if.ret_mem_wdata = pc ^ 32'hA5A5_0000;
        ret_if.ret_mem_rmask = rmask;
        ret_if.ret_mem_wmask = wmask;
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            @(negedge clock);
            if (ret_if.ret_ready === 1'b1) begin
                @(posedge clock);
                #1;
                ok = 1'b1;
            end
        end
        ret_if.ret_valid = 1'b0;
        if (ok) begin
            e = '{order: exp_order, insn: insn, trap: exp_trap, halt: halt, intr: 1'b0,
                  mode: 2'b11, rs1_addr: 5'd2, rs2_addr: 5'd3, rd_addr: exp_rd,
                  rs1_rdata: pc + 32'h11, rs2_rdata: pc + 32'h22, rd_wdata: exp_rdw,
                  pc_rdata: pc, pc_wdata: pc + 32'd4, mem_addr: pc + 32'h100,
                  rmask: exp_rmask, wmask: exp_wmask, mem_rdata: exp_mrdata,
                  mem_wdata: pc ^ 32'hA5A5_0000};
            exp_q.push_back(e);
            exp_order++;
        end else begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic resp(input logic [31:0] mrd, input logic [31:0] rdw);
        ld_resp_valid = 1'b1;
        ld_mem_rdata  = mrd;
        ld_rd_wdata   = rdw;
        @(posedge clock);
        #1;
        ld_resp_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(posedge clock);
            #1;
        end
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        ret_if.ret_valid = 1'b0;
        ld_resp_valid    = 1'b0;
        reset            = 1'b0;
        exp_q.delete();
        exp_order = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    localparam logic [31:0] LW = 32'h0001_2283;

    initial begin
        bit ok, ok5;
        ret_if.ret_valid = 1'b0;
        // Reset state
        do_reset();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", ret_if.ret_ready, 0);
        chk("rst_valid", rvfi_valid, 0);
        chk("rst_order", rvfi_order, 0);
        chk("rst_mode", rvfi_mode, 0);
        chk("rst_ld_err", ld_err, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", ret_if.ret_ready, 1);
        @(posedge clock);
        #1;

        // addi x1,x0,5 -> emits one cycle after acceptance
        offer(32'h0050_0093, 32'h0, 5'd1, 32'd5, 4'h0, 4'h0, 1'b0, 1'b0,
              1'b0, 5'd1, 32'd5, 4'h0, 4'h0, 32'h0, 10, ok);
        chk("accept_addi", ok, 1);
        @(negedge clock);
        chk("addi_not_yet", rvfi_valid, 0);
        @(negedge clock);
        chk("addi_emit", rvfi_valid, 1);
        chk("addi_order", rvfi_order, 0);

        // Illegal instructions canonicalised; rmask on an illegal must not stall
        @(posedge clock);
        #1;
        offer(32'h0, 32'h4, 5'd3, 32'hFF, 4'h0, 4'hF, 1'b1, 1'b0,
              1'b1, 5'd0, 32'h0, 4'h0, 4'h0, 32'h0, 10, ok);
        chk("accept_ill0", ok, 1);
        offer(32'h0, 32'h8, 5'd4, 32'h12, 4'hF, 4'h0, 1'b1, 1'b0,
              1'b1, 5'd0, 32'h0, 4'h0, 4'h0, 32'h0, 10, ok);
        chk("accept_ill1", ok, 1);
        // rd_addr 0 suppresses rd_wdata
        offer(32'h0990_0013, 32'hC, 5'd0, 32'h99, 4'h0, 4'h0, 1'b0, 1'b0,
              1'b0, 5'd0, 32'h0, 4'h0, 4'h0, 32'h0, 10, ok);
        chk("accept_x0", ok, 1);
        wait_drain("drain_illegal");

        // Load then two ALU ops; response arrives later
        do_reset();
        offer(LW, 32'h20, 5'd5, 32'h0, 4'hF, 4'h0, 1'b0, 1'b0,
              1'b0, 5'd5, 32'hDEADBEEF, 4'hF, 4'h0, 32'hDEADBEEF, 10, ok);
        offer(32'h0010_0313, 32'h24, 5'd6, 32'd1, 4'h0, 4'h0, 1'b0, 1'b0,
              1'b0, 5'd6, 32'd1, 4'h0, 4'h0, 32'h0, 10, ok);
        offer(32'h0020_83B3, 32'h28, 5'd7, 32'd2, 4'h0, 4'h0, 1'b0, 1'b0,
              1'b0, 5'd7, 32'd2, 4'h0, 4'h0, 32'h0, 10, ok);
        repeat (3) begin
            @(negedge clock);
            chk("ld_block", rvfi_valid, 0);
        end
        @(posedge clock);
        #1;
        resp(32'hDEADBEEF, 32'hDEADBEEF);
        @(negedge clock);
        chk("ld_resp_lat", rvfi_valid, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("ld_seq_valid", rvfi_valid, 1);
            chk("ld_seq_order", rvfi_order, 64'(k));
        end
        @(negedge clock);
        chk("ld_seq_end", rvfi_valid, 0);
        @(posedge clock);
        #1;
        wait_drain("drain_load");

        // Fill with loads: ready drops after DEPTH accepts
        offer(LW, 32'h40, 5'd8, 32'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 5'd8, 32'h1000, 4'hF, 4'h0, 32'h2000, 10, ok);
        offer(LW, 32'h44, 5'd9, 32'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h1001, 4'hF, 4'h0, 32'h2001, 10, ok);
        offer(LW, 32'h48, 5'd0, 32'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 4'hF, 4'h0, 32'h2002, 10, ok);
        offer(LW, 32'h4C, 5'd10, 32'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 5'd10, 32'h1003, 4'hF, 4'h0, 32'h2003, 10, ok);
        chk("fill_4th_accept", ok, 1);
        @(negedge clock);
        chk("full_ready", ret_if.ret_ready, 0);
        @(posedge clock);
        #1;
        fork
            offer(LW, 32'h50, 5'd11, 32'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 5'd11, 32'h1004, 4'hF, 4'h0, 32'h2004, 12, ok5);
            begin
                repeat (3) begin
                    @(negedge clock);
                    chk("full_hold", ret_if.ret_ready, 0);
                end
                @(posedge clock);
                #1;
                resp(32'h2000, 32'h1000);
                @(negedge clock);
                chk("no_bypass", ret_if.ret_ready, 0);
            end
        join
        chk("fifth_accept", ok5, 1);
        resp(32'h2001, 32'h1001);
        resp(32'h2002, 32'h1002);
        resp(32'h2003, 32'h1003);
        resp(32'h2004, 32'h1004);
        wait_drain("drain_fill");

        // Response with nothing pending
        @(negedge clock);
        chk("ld_err_clear", ld_err, 0);
        @(posedge clock);
        #1;
        resp(32'hBAD, 32'hBAD);
        @(negedge clock);
        chk("ld_err_set", ld_err, 1);
        chk("ld_err_no_emit", rvfi_valid, 0);
        repeat (3) @(negedge clock);
        chk("ld_err_sticky", ld_err, 1);
        @(posedge clock);
        #1;
        // Load accepted in the same cycle as a response is not completed by it
        fork
            offer(LW, 32'h80, 5'd12, 32'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 5'd12, 32'h3333, 4'hF, 4'h0, 32'h4444, 10, ok);
            resp(32'h5555, 32'h6666);
        join
        repeat (3) begin
            @(negedge clock);
            chk("same_cycle_pending", rvfi_valid, 0);
        end
        @(posedge clock);
        #1;
        resp(32'h4444, 32'h3333);
        wait_drain("drain_same_cycle");

        // Halt, then reset with two entries still buffered
        do_reset();
        @(negedge clock);
        chk("rst_ld_err_cleared", ld_err, 0);
        @(posedge clock);
        #1;
        offer(LW, 32'h0, 5'd5, 32'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 5'd5, 32'h77, 4'hF, 4'h0, 32'h88, 10, ok);
        offer(32'h0010_0073, 32'h4, 5'd0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 4'h0, 4'h0, 32'h0, 10, ok);
        offer(LW, 32'h8, 5'd6, 32'h0, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 5'd6, 32'h1, 4'hF, 4'h0, 32'h1, 10, ok);
        offer(32'h0090_0393, 32'hC, 5'd7, 32'd9, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 5'd7, 32'd9, 4'h0, 4'h0, 32'h0, 10, ok);
        chk("halt_setup_accept", ok, 1);
        resp(32'h88, 32'h77);
        for (int c = 0; c < 20 && exp_q.size() > 2; c++) begin
            @(posedge clock);
            #1;
        end
        chk("halt_emitted", exp_q.size(), 2);
        @(negedge clock);
        chk("halt_ready", ret_if.ret_ready, 0);
        @(posedge clock);
        #1;
        offer(32'h0010_0093, 32'h10, 5'd1, 32'd1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 5'd1, 32'd1, 4'h0, 4'h0, 32'h0, 4, ok);
        chk("halt_block", ok, 0);
        do_reset();
        @(negedge clock);
        chk("post_halt_ready", ret_if.ret_ready, 1);
        repeat (4) begin
            @(negedge clock);
            chk("discarded_no_emit", rvfi_valid, 0);
        end
        @(posedge clock);
        #1;
        offer(32'h0330_0193, 32'h100, 5'd3, 32'h33, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 5'd3, 32'h33, 4'h0, 4'h0, 32'h0, 10, ok);
        chk("post_reset_accept", ok, 1);
        @(negedge clock);
        @(negedge clock);
        chk("restart_valid", rvfi_valid, 1);
        chk("restart_order", rvfi_order, 0);
        @(posedge clock);
        #1;
        wait_drain("drain_final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
